// File: rtl/sm_twi_slave.sv
// TWI (I2C) target with an 8-byte register bank, a pointer byte for writes,
// sequential auto-incrementing reads and a side read port for the board top.
module sm_twi_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [2:0] regAddr,
    output logic [7:0] regData,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic       busy
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] ADDR   = 4'd1;
    localparam logic [3:0] ACK_A  = 4'd2;
    localparam logic [3:0] PTR    = 4'd3;
    localparam logic [3:0] ACK_P  = 4'd4;
    localparam logic [3:0] WDATA  = 4'd5;
    localparam logic [3:0] ACK_W  = 4'd6;
    localparam logic [3:0] RDATA  = 4'd7;
    localparam logic [3:0] RACK   = 4'd8;
    localparam logic [3:0] IGNORE = 4'd9;

    logic       scl_s1, scl_s2, scl_prev;
    logic       sda_s1, sda_s2, sda_prev;
    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [2:0] ptr;
    logic       rw;
    logic       commit_pend;
    logic       sda_oe;
    logic [7:0] bank [8];

    logic       scl_rise, scl_fall, start_c, stop_c;
    logic       rx_phase, rx_bit, rx_last;
    logic [7:0] rx_byte;

    assign sda      = sda_oe ? 1'b0 : 1'bz;
    assign regData  = bank[regAddr];

    assign scl_rise = scl_s2 & ~scl_prev;
    assign scl_fall = ~scl_s2 & scl_prev;
    assign start_c  = ~sda_s2 & sda_prev & scl_s2;
    assign stop_c   = sda_s2 & ~sda_prev & scl_s2;

    assign rx_phase = (state == ADDR) || (state == PTR) || (state == WDATA);
    assign rx_bit   = rx_phase && scl_rise && !bit_cnt[3];
    assign rx_last  = rx_bit && (bit_cnt == 4'd7);
    assign rx_byte  = {shreg[6:0], sda_s2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchronizers come out of reset at the idle-bus level so no edge is seen.
            scl_s1      <= 1'b1;
            scl_s2      <= 1'b1;
            scl_prev    <= 1'b1;
            sda_s1      <= 1'b1;
            sda_s2      <= 1'b1;
            sda_prev    <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shreg       <= 8'h00;
            ptr         <= 3'd0;
            rw          <= 1'b0;
            commit_pend <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 3'd0;
            for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
        end else begin
            scl_s1    <= scl;
            scl_s2    <= scl_s1;
            scl_prev  <= scl_s2;
            sda_s1    <= sda;
            sda_s2    <= sda_s1;
            sda_prev  <= sda_s2;
            wr_strobe <= 1'b0;

            if (start_c) begin
                state       <= ADDR;
                bit_cnt     <= 4'd0;
                sda_oe      <= 1'b0;
                commit_pend <= 1'b0;
            end else if (stop_c) begin
                state       <= IDLE;
                bit_cnt     <= 4'd0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
                commit_pend <= 1'b0;
            end else begin
                if (commit_pend) begin
                    bank[ptr]   <= shreg;
                    wr_addr     <= ptr;
                    wr_strobe   <= 1'b1;
                    ptr         <= ptr + 3'd1;
                    commit_pend <= 1'b0;
                end

                if (rx_bit) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                end

                case (state)
                    ADDR: begin
                        if (rx_last) begin
                            rw <= sda_s2;
                            if (rx_byte[7:1] != SLAVE_ADDR) state <= IGNORE;
                        end else if (scl_fall && bit_cnt[3]) begin
                            state  <= ACK_A;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                    ACK_A: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shreg   <= bank[ptr];
                                ptr     <= ptr + 3'd1;
                                sda_oe  <= ~bank[ptr][7];
                                bit_cnt <= 4'd1;
                                state   <= RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (rx_last) begin
                            ptr <= rx_byte[2:0];
                        end else if (scl_fall && bit_cnt[3]) begin
                            state  <= ACK_P;
                            sda_oe <= 1'b1;
                        end
                    end
                    ACK_P, ACK_W: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: begin
                        // Commit lands one clk later so a START/STOP in that cycle discards it.
                        if (rx_last) begin
                            commit_pend <= 1'b1;
                        end else if (scl_fall && bit_cnt[3]) begin
                            state  <= ACK_W;
                            sda_oe <= 1'b1;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt[3]) begin
                                sda_oe <= 1'b0;
                                state  <= RACK;
                            end else begin
                                sda_oe  <= ~shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise && sda_s2) begin
                            state <= IGNORE;
                        end else if (scl_fall) begin
                            shreg   <= bank[ptr];
                            ptr     <= ptr + 3'd1;
                            sda_oe  <= ~bank[ptr][7];
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
